// File: rtl/l1_mem_sched_if.sv
// Purpose: line-granular memory bus shared by the L1 cache ports and the memory
//          side of the scheduler.
// Signals: req_valid/req_ready handshake with req_rw, req_addr, req_byteen,
//          req_data, req_tag; rsp_valid/rsp_ready handshake with rsp_data, rsp_tag.
// Modports: master issues requests and accepts responses; slave does the reverse.
interface l1_mem_sched_if #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned TAG_WIDTH  = 8
);
    localparam int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_rw;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [BYTEEN_WIDTH-1:0] req_byteen;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [TAG_WIDTH-1:0]    req_tag;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [TAG_WIDTH-1:0]    rsp_tag;

    modport master (
        output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/l1_mem_sched.sv
// Purpose: shares one memory request channel between the icache and dcache memory
//          ports (icache priority, dcache anti-starvation override, per-source read
//          credits) and routes memory responses back to the owning cache.
// Ports:  clk, reset (async, active-low)
//         ic   - icache port (slave side; requests are always reads)
//         dc   - dcache port (slave side; reads and writebacks)
//         mem  - memory port (master side; tag = {src_tag, src_id}, src_id 1 = dcache)
//         busy - request register occupied or any read outstanding
module l1_mem_sched #(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned MAX_PENDING  = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    l1_mem_sched_if.slave  ic,
    l1_mem_sched_if.slave  dc,
    l1_mem_sched_if.master mem,
    output logic           busy
);
    localparam int unsigned PEND_W       = $clog2(MAX_PENDING + 1);
    localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8;

    logic [PEND_W-1:0]   ic_pend;
    logic [PEND_W-1:0]   dc_pend;
    logic [STARVE_W-1:0] starve_cnt;

    logic ic_elig;
    logic dc_elig;
    logic force_dc;
    logic grant_ic;
    logic grant_dc;
    logic can_load;
    logic ic_acc;
    logic dc_acc;
    logic ic_inc;
    logic ic_dec;
    logic dc_inc;
    logic dc_dec;
    logic rsp_sel_dc;
    logic rsp_fire;

    // The icache port carries no write payload; these inputs are intentionally ignored.
    logic unused_ic;
    assign unused_ic = ^{ic.req_rw, ic.req_byteen, ic.req_data};

    // Eligibility and grant: writes need no read credit; a starved dcache overrides icache.
    always_comb begin
        ic_elig  = ic.req_valid && (ic_pend < PEND_W'(MAX_PENDING));
        dc_elig  = dc.req_valid && (dc.req_rw || (dc_pend < PEND_W'(MAX_PENDING)));
        force_dc = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && dc_elig;
        grant_dc = force_dc || (!ic_elig && dc_elig);
        grant_ic = ic_elig && !force_dc;
        can_load = !mem.req_valid || mem.req_ready;
        ic_acc   = grant_ic && can_load;
        dc_acc   = grant_dc && can_load;
    end

    assign ic.req_ready = ic_acc;
    assign dc.req_ready = dc_acc;

    // Response routing is a pure passthrough selected by the source id bit.
    always_comb begin
        rsp_sel_dc    = mem.rsp_tag[0];
        ic.rsp_valid  = mem.rsp_valid && !rsp_sel_dc;
        dc.rsp_valid  = mem.rsp_valid && rsp_sel_dc;
        ic.rsp_data   = mem.rsp_data;
        dc.rsp_data   = mem.rsp_data;
        ic.rsp_tag    = mem.rsp_tag[TAG_WIDTH:1];
        dc.rsp_tag    = mem.rsp_tag[TAG_WIDTH:1];
        mem.rsp_ready = rsp_sel_dc ? dc.rsp_ready : ic.rsp_ready;
        rsp_fire      = mem.rsp_valid && mem.rsp_ready;
    end

    // Credit events: reads consume a credit on acceptance, responses return it.
    always_comb begin
        ic_inc = ic_acc;
        dc_inc = dc_acc && !dc.req_rw;
        ic_dec = rsp_fire && !rsp_sel_dc;
        dc_dec = rsp_fire && rsp_sel_dc;
    end

    // Single-entry request register; payload holds while valid && !ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.req_valid  <= 1'b0;
            mem.req_rw     <= 1'b0;
            mem.req_addr   <= '0;
            mem.req_byteen <= '0;
            mem.req_data   <= '0;
            mem.req_tag    <= '0;
        end else if (ic_acc) begin
            mem.req_valid  <= 1'b1;
            mem.req_rw     <= 1'b0;
            mem.req_addr   <= ic.req_addr;
            mem.req_byteen <= BYTEEN_WIDTH'(0);
            mem.req_data   <= DATA_WIDTH'(0);
            mem.req_tag    <= {ic.req_tag, 1'b0};
        end else if (dc_acc) begin
            mem.req_valid  <= 1'b1;
            mem.req_rw     <= dc.req_rw;
            mem.req_addr   <= dc.req_addr;
            mem.req_byteen <= dc.req_byteen;
            mem.req_data   <= dc.req_data;
            mem.req_tag    <= {dc.req_tag, 1'b1};
        end else if (mem.req_ready) begin
            mem.req_valid  <= 1'b0;
        end
    end

    // Anti-starvation counter: counts icache wins while dcache was waiting eligible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (dc_acc) begin
            starve_cnt <= '0;
        end else if (ic_acc && dc_elig && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // Outstanding-read credits; simultaneous +1/-1 cancel, underflow saturates at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ic_pend <= '0;
            dc_pend <= '0;
        end else begin
            if (ic_inc && !ic_dec) begin
                ic_pend <= ic_pend + PEND_W'(1);
            end else if (ic_dec && !ic_inc && (ic_pend != '0)) begin
                ic_pend <= ic_pend - PEND_W'(1);
            end
            if (dc_inc && !dc_dec) begin
                dc_pend <= dc_pend + PEND_W'(1);
            end else if (dc_dec && !dc_inc && (dc_pend != '0)) begin
                dc_pend <= dc_pend - PEND_W'(1);
            end
        end
    end

    assign busy = mem.req_valid || (ic_pend != '0) || (dc_pend != '0);

    // A response with no outstanding read from that source indicates a protocol error.
    ic_underflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(ic_dec && !ic_inc && (ic_pend == '0)))
        else $error("l1_mem_sched: icache response with no outstanding read");

    dc_underflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(dc_dec && !dc_inc && (dc_pend == '0)))
        else $error("l1_mem_sched: dcache response with no outstanding read");
endmodule

// File: tb/tb_l1_mem_sched.sv
module tb_l1_mem_sched;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 512;
    localparam int unsigned TW = 8;

    logic clk;
    logic reset;
    logic busy;

    l1_mem_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW))     ic_if ();
    l1_mem_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW))     dc_if ();
    l1_mem_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW + 1)) mem_if ();

    l1_mem_sched #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TAG_WIDTH   (TW),
        .MAX_PENDING (8),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ic   (ic_if.slave),
        .dc   (dc_if.slave),
        .mem  (mem_if.master),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   rsp_pat;
    logic [DW-1:0]   wr_pat;
    logic [DW/8-1:0] be_pat;

    typedef struct {
        logic ic_v;
        logic dc_v;
        logic dc_rw;
        logic exp_ic;
        logic exp_dc;
    } row_t;

    row_t rows [19];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ic_if.req_valid = rows[i].ic_v;
            ic_if.req_addr  = AW'(32'h100 + i);
            ic_if.req_tag   = TW'(i);
            dc_if.req_valid = rows[i].dc_v;
            dc_if.req_rw    = rows[i].dc_rw;
            dc_if.req_addr  = AW'(32'h200 + i);
            dc_if.req_tag   = TW'(32'h80 + i);
            #1;
            chk($sformatf("row%0d ic_req_ready", i), DW'(ic_if.req_ready), DW'(rows[i].exp_ic));
            chk($sformatf("row%0d dc_req_ready", i), DW'(dc_if.req_ready), DW'(rows[i].exp_dc));
            step();
            if (rows[i].exp_ic) begin
                chk($sformatf("row%0d mem_req_valid", i), DW'(mem_if.req_valid), DW'(1));
                chk($sformatf("row%0d mem_req_tag", i), DW'(mem_if.req_tag), DW'({TW'(i), 1'b0}));
                chk($sformatf("row%0d mem_req_addr", i), DW'(mem_if.req_addr), DW'(32'h100 + i));
                chk($sformatf("row%0d mem_req_rw", i), DW'(mem_if.req_rw), DW'(0));
            end else if (rows[i].exp_dc) begin
                chk($sformatf("row%0d mem_req_valid", i), DW'(mem_if.req_valid), DW'(1));
                chk($sformatf("row%0d mem_req_tag", i), DW'(mem_if.req_tag), DW'({TW'(32'h80 + i), 1'b1}));
                chk($sformatf("row%0d mem_req_addr", i), DW'(mem_if.req_addr), DW'(32'h200 + i));
                chk($sformatf("row%0d mem_req_rw", i), DW'(mem_if.req_rw), DW'(rows[i].dc_rw));
                if (rows[i].dc_rw) begin
                    chk($sformatf("row%0d mem_req_data", i), mem_if.req_data, wr_pat);
                    chk($sformatf("row%0d mem_req_byteen", i), DW'(mem_if.req_byteen), DW'(be_pat));
                end
            end
        end
    endtask

    initial begin
        // Starvation pattern ic x4, dc; then ic runs out of credit (8 reads) and dc proceeds.
        for (int i = 0; i < 4; i++) rows[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rows[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 5; i < 9; i++) rows[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rows[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rows[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        // ic out of credit: dc reads fill dc_pend 3 -> 8, then both blocked, then a write.
        for (int i = 11; i < 16; i++) rows[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rows[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rows[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        rows[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rsp_pat = {16{32'hDEADBEEF}};
        wr_pat  = {8{64'h0123_4567_89AB_CDEF}};
        be_pat  = {8{8'hF0}};

        reset              = 1'b0;
        ic_if.req_valid    = 1'b0;
        ic_if.req_rw       = 1'b0;
        ic_if.req_addr     = '0;
        ic_if.req_byteen   = '0;
        ic_if.req_data     = '0;
        ic_if.req_tag      = '0;
        ic_if.rsp_ready    = 1'b1;
        dc_if.req_valid    = 1'b0;
        dc_if.req_rw       = 1'b0;
        dc_if.req_addr     = '0;
        dc_if.req_byteen   = be_pat;
        dc_if.req_data     = wr_pat;
        dc_if.req_tag      = '0;
        dc_if.rsp_ready    = 1'b1;
        mem_if.req_ready   = 1'b1;
        mem_if.rsp_valid   = 1'b0;
        mem_if.rsp_data    = rsp_pat;
        mem_if.rsp_tag     = '0;

        // Reset state
        #1;
        chk("reset mem_req_valid", DW'(mem_if.req_valid), DW'(0));
        chk("reset busy", DW'(busy), DW'(0));
        chk("reset ic_req_ready", DW'(ic_if.req_ready), DW'(0));
        chk("reset dc_req_ready", DW'(dc_if.req_ready), DW'(0));
        step();
        step();
        reset = 1'b1;

        // Single icache read and its response
        ic_if.req_valid = 1'b1;
        ic_if.req_addr  = AW'(32'h10);
        ic_if.req_tag   = TW'(8'h3);
        #1;
        chk("t1 ic_req_ready", DW'(ic_if.req_ready), DW'(1));
        step();
        chk("t1 mem_req_valid", DW'(mem_if.req_valid), DW'(1));
        chk("t1 mem_req_addr", DW'(mem_if.req_addr), DW'(32'h10));
        chk("t1 mem_req_tag", DW'(mem_if.req_tag), DW'(9'h006));
        chk("t1 busy", DW'(busy), DW'(1));
        chk("t1 ic_pend", DW'(dut.ic_pend), DW'(1));
        ic_if.req_valid  = 1'b0;
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_tag   = 9'h006;
        #1;
        chk("t1 ic_rsp_valid", DW'(ic_if.rsp_valid), DW'(1));
        chk("t1 ic_rsp_tag", DW'(ic_if.rsp_tag), DW'(8'h3));
        chk("t1 ic_rsp_data", ic_if.rsp_data, rsp_pat);
        chk("t1 dc_rsp_valid", DW'(dc_if.rsp_valid), DW'(0));
        chk("t1 mem_rsp_ready", DW'(mem_if.rsp_ready), DW'(1));
        step();
        mem_if.rsp_valid = 1'b0;
        #1;
        chk("t1 ic_pend after rsp", DW'(dut.ic_pend), DW'(0));
        chk("t1 busy after rsp", DW'(busy), DW'(0));

        // Starvation pattern and credit exhaustion
        apply_rows(0, 10);
        chk("credit ic_pend", DW'(dut.ic_pend), DW'(8));
        chk("credit dc_pend", DW'(dut.dc_pend), DW'(3));

        // One ic response: credit usable only in the following cycle
        ic_if.req_valid  = 1'b1;
        ic_if.req_addr   = AW'(32'h300);
        ic_if.req_tag    = TW'(8'h40);
        dc_if.req_valid  = 1'b0;
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_tag   = 9'h00A;
        #1;
        chk("release same-cycle ic_req_ready", DW'(ic_if.req_ready), DW'(0));
        chk("release ic_rsp_tag", DW'(ic_if.rsp_tag), DW'(8'h05));
        step();
        mem_if.rsp_valid = 1'b0;
        #1;
        chk("release next-cycle ic_req_ready", DW'(ic_if.req_ready), DW'(1));
        step();
        chk("release mem_req_tag", DW'(mem_if.req_tag), DW'(9'h080));
        chk("release ic_pend", DW'(dut.ic_pend), DW'(8));

        // dc reads to full credit, blocked, then a write with no credit
        apply_rows(11, 18);
        chk("write dc_pend", DW'(dut.dc_pend), DW'(8));
        chk("idle mem_req_valid", DW'(mem_if.req_valid), DW'(0));

        // Drain ic credits
        ic_if.req_valid = 1'b0;
        dc_if.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_if.rsp_valid = 1'b1;
            mem_if.rsp_tag   = {TW'(i), 1'b0};
            step();
        end
        chk("drain ic_pend", DW'(dut.ic_pend), DW'(0));

        // dcache response backpressure, then drain dc credits
        mem_if.rsp_tag  = {TW'(8'h21), 1'b1};
        dc_if.rsp_ready = 1'b0;
        #1;
        chk("dc rsp blocked mem_rsp_ready", DW'(mem_if.rsp_ready), DW'(0));
        chk("dc rsp dc_rsp_valid", DW'(dc_if.rsp_valid), DW'(1));
        chk("dc rsp ic_rsp_valid", DW'(ic_if.rsp_valid), DW'(0));
        chk("dc rsp dc_rsp_tag", DW'(dc_if.rsp_tag), DW'(8'h21));
        step();
        chk("dc rsp blocked dc_pend", DW'(dut.dc_pend), DW'(8));
        dc_if.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_if.rsp_tag = {TW'(32'h80 + i), 1'b1};
            step();
        end
        mem_if.rsp_valid = 1'b0;
        #1;
        chk("drain dc_pend", DW'(dut.dc_pend), DW'(0));
        chk("drain busy", DW'(busy), DW'(0));

        // Memory backpressure holds the request register
        ic_if.req_valid = 1'b1;
        ic_if.req_addr  = AW'(32'h55);
        ic_if.req_tag   = TW'(8'h7);
        #1;
        chk("stall load ic_req_ready", DW'(ic_if.req_ready), DW'(1));
        step();
        mem_if.req_ready = 1'b0;
        ic_if.req_addr   = AW'(32'h56);
        ic_if.req_tag    = TW'(8'h8);
        dc_if.req_valid  = 1'b1;
        dc_if.req_rw     = 1'b0;
        dc_if.req_addr   = AW'(32'h66);
        dc_if.req_tag    = TW'(8'h11);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d ic_req_ready", k), DW'(ic_if.req_ready), DW'(0));
            chk($sformatf("stall%0d dc_req_ready", k), DW'(dc_if.req_ready), DW'(0));
            chk($sformatf("stall%0d mem_req_valid", k), DW'(mem_if.req_valid), DW'(1));
            chk($sformatf("stall%0d mem_req_addr", k), DW'(mem_if.req_addr), DW'(32'h55));
            chk($sformatf("stall%0d mem_req_tag", k), DW'(mem_if.req_tag), DW'(9'h00E));
            step();
        end
        mem_if.req_ready = 1'b1;
        #1;
        chk("unstall ic_req_ready", DW'(ic_if.req_ready), DW'(1));
        chk("unstall dc_req_ready", DW'(dc_if.req_ready), DW'(0));
        step();
        chk("unstall mem_req_addr", DW'(mem_if.req_addr), DW'(32'h56));
        chk("unstall mem_req_tag", DW'(mem_if.req_tag), DW'(9'h010));

        // Response and new read from the same source in one cycle
        dc_if.req_valid  = 1'b0;
        ic_if.req_addr   = AW'(32'h57);
        ic_if.req_tag    = TW'(8'h9);
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_tag   = 9'h00E;
        #1;
        chk("same-cycle ic_req_ready", DW'(ic_if.req_ready), DW'(1));
        chk("same-cycle ic_rsp_valid", DW'(ic_if.rsp_valid), DW'(1));
        step();
        mem_if.rsp_valid = 1'b0;
        ic_if.req_valid  = 1'b0;
        chk("same-cycle ic_pend", DW'(dut.ic_pend), DW'(2));

        // Async reset mid-transaction
        dc_if.req_valid = 1'b1;
        dc_if.req_rw    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dc_if.req_addr = AW'(32'h400 + i);
            dc_if.req_tag  = TW'(i);
            #1;
            chk($sformatf("pre-reset%0d dc_req_ready", i), DW'(dc_if.req_ready), DW'(1));
            step();
        end
        dc_if.req_valid = 1'b0;
        chk("pre-reset dc_pend", DW'(dut.dc_pend), DW'(3));
        chk("pre-reset mem_req_valid", DW'(mem_if.req_valid), DW'(1));
        reset = 1'b0;
        #1;
        chk("async reset mem_req_valid", DW'(mem_if.req_valid), DW'(0));
        chk("async reset busy", DW'(busy), DW'(0));
        chk("async reset dc_pend", DW'(dut.dc_pend), DW'(0));
        chk("async reset ic_pend", DW'(dut.ic_pend), DW'(0));
        step();
        reset = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
